// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, state encoding and helpers for the binary-to-BCD converter
package seg_pkg;
  localparam int DIGITS_DEF = 8;
  localparam int BCD_W = 4;
  localparam logic [63:0] MAX_VAL = 64'd99_999_999;
  localparam logic [BCD_W*DIGITS_DEF-1:0] SAT_PATTERN = {DIGITS_DEF{4'h9}};
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic logic [63:0] max_val(input int digits);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < digits; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: converter handshake bus (in_valid/in_ready/in_bin in, out_valid/bcd_out/ovf out, blank_mask with BIN2BCD_BLANK_EN)
interface bin2bcd_seq_if
  import seg_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int DIGITS = DIGITS_DEF
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_bin;
  logic out_valid;
  logic [BCD_W*DIGITS-1:0] bcd_out;
  logic ovf;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_mask;
  modport master (output in_valid, in_bin, input in_ready, out_valid, bcd_out, ovf, blank_mask);
  modport slave (input in_valid, in_bin, output in_ready, out_valid, bcd_out, ovf, blank_mask);
`else
  modport master (output in_valid, in_bin, input in_ready, out_valid, bcd_out, ovf);
  modport slave (input in_valid, in_bin, output in_ready, out_valid, bcd_out, ovf);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble digit correction, d >= 5 gets 3 added (4-bit, no carry out)
module bcd_digit_adj
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);
  assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: double-dabble binary->BCD converter; ports clk, rst (sync active-low), bus (slave: in_valid/in_ready/in_bin -> out_valid/bcd_out/ovf, plus blank_mask when BIN2BCD_BLANK_EN is defined)
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int DIGITS = DIGITS_DEF
)(
  input logic clk,
  input logic rst,
  bin2bcd_seq_if.slave bus
);
  localparam int BW = BCD_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [63:0] MAX_D = max_val(DIGITS);
  localparam bit FITS = WIDTH >= 64 || (MAX_D >> WIDTH) == 64'd0;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_D);
  localparam logic [BW-1:0] SAT = {DIGITS{4'h9}};
  state_t state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, adj, shf, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d, done;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic [BW-1:0] bcd_out_q, bcd_out_d;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.d(bcd_q[BCD_W*g +: BCD_W]), .q(adj[BCD_W*g +: BCD_W]));
  end
  assign shf = {adj[BW-2:0], bin_q[WIDTH-1]};
  assign done = state_q == SHIFT && cnt_q == CW'(1);
  assign res = sat_q ? SAT : shf;
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    out_valid_d = 1'b0;
    bcd_out_d = bcd_out_q;
    ovf_d = ovf_q;
    if (state_q == IDLE) begin
      if (bus.in_valid) begin
        bin_d = bus.in_bin;
        bcd_d = '0;
        cnt_d = CW'(WIDTH);
        sat_d = FITS && bus.in_bin > MAX_W;
        state_d = SHIFT;
      end
    end else begin
      bin_d = bin_q << 1;
      bcd_d = shf;
      cnt_d = cnt_q - CW'(1);
      if (done) begin
        bcd_out_d = res;
        ovf_d = sat_q;
        out_valid_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic zero;
  always_comb begin
    blank_d = blank_q;
    zero = 1'b1;
    if (done) begin
      blank_d[0] = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
        zero = zero && res[BCD_W*i +: BCD_W] == 4'd0;
        blank_d[i] = zero;
      end
    end
  end
  always_ff @(posedge clk) blank_q <= !rst ? '0 : blank_d;
  assign bus.blank_mask = blank_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      out_valid_q <= 1'b0;
      bcd_out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      out_valid_q <= out_valid_d;
      bcd_out_q <= bcd_out_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd_out = bcd_out_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq with a division-based reference model
module tb_bin2bcd_seq;
  import seg_pkg::*;
  localparam int W = 27;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();
  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] bcd;
    logic ovf;
    logic [7:0] blank;
    int acc;
  } exp_t;
  exp_t sb[$];
  int outs[$];
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic exp_t model(input int unsigned v, input int acc);
    exp_t e;
    logic [31:0] b;
    logic z;
    b = '0;
    e.ovf = v > 32'd99_999_999;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    if (e.ovf) b = 32'h9999_9999;
    e.bcd = b;
    e.blank = '0;
    z = 1'b1;
    for (int i = 7; i > 0; i--) begin
      z = z && b[4*i +: 4] == 4'd0;
      e.blank[i] = z;
    end
    e.acc = acc;
    return e;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (!rst) sb.delete();
    else if (bus.in_valid && bus.in_ready) sb.push_back(model(int'(bus.in_bin), cyc));
  end
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (bus.out_valid) begin
      outs.push_back(cyc);
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("bcd_out", bus.bcd_out, e.bcd);
        chk("ovf", bus.ovf, e.ovf);
        chk("latency", cyc - e.acc, 27);
`ifdef BIN2BCD_BLANK_EN
        chk("blank_mask", bus.blank_mask, e.blank);
`endif
      end
    end
  end
  task automatic send(input logic [26:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_bin = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("done_timeout", sb.size(), 0);
  endtask
  initial begin
    int bad;
    bus.in_valid = 1'b0;
    bus.in_bin = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_bcd", bus.bcd_out, 0);
    chk("rst_ovf", bus.ovf, 0);
`ifdef BIN2BCD_BLANK_EN
    chk("rst_blank", bus.blank_mask, 0);
`endif
    rst = 1'b1;
    send(27'd0);
    wait_done();
    send(27'd12_345_678);
    chk("busy", bus.in_ready, 0);
    wait_done();
    send(27'd1234);
    wait_done();
    send(27'd99_999_999);
    wait_done();
    send(27'd100_000_000);
    wait_done();
    send(27'd134_217_727);
    wait_done();
    outs.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 90; k++) begin
      bus.in_bin = k % 3 == 0 ? 27'd555 : 27'd87_654_321;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_done();
    chk("b2b_count", outs.size(), 4);
    for (int i = 0; i + 1 < outs.size(); i++) chk("b2b_spacing", outs[i+1] - outs[i], 28);
    send(27'd7777);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_bcd", bus.bcd_out, 0);
    chk("mid_rst_ovf", bus.ovf, 0);
    outs.delete();
    repeat (30) @(negedge clk);
    chk("mid_rst_no_pulse", outs.size(), 0);
    send(27'd42);
    wait_done();
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.bcd_out !== 32'h0000_0042 || bus.out_valid !== 1'b0) bad++;
    end
    chk("hold", bad, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-add-3 / double-dabble). It sits directly upstream of the 8-digit seven-segment scanner.
- Accepts one binary value per handshake and produces 8 packed BCD digits after a fixed latency.
- The scanner latches and displays those digits.
- Digit 0 is the least significant digit, bits [3:0]. It drives the rightmost display position.

Parameters:
- WIDTH, 27, binary input width. 2^27 covers 99,999,999.
- DIGITS, 8, number of BCD output digits. Equals the scanner's position count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  in_bin is valid
- in_ready  out  1  converter idle; will accept this cycle
- in_bin  in  WIDTH  unsigned binary value
- out_valid  out  1  single-cycle pulse: bcd_out/ovf just updated
- bcd_out  out  4*DIGITS  packed BCD result, held between conversions
- ovf  out  1  last accepted input exceeded 10^DIGITS-1

Behaviour:
- Reset:
  - Applied at posedge clk when rst==0. It overrides everything, including a conversion in progress.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, bcd_out=0, ovf=0, internal shift/bit counter=0.
  - A partially converted value is discarded, and no out_valid is produced for it.
- States:
  - IDLE:
    - in_ready=1.
    - On an edge with in_valid&&in_ready:
      - load in_bin into the binary shift register;
      - clear the BCD accumulator;
      - load bit counter=WIDTH;
      - capture sat = (in_bin > 10^DIGITS-1);
      - go to SHIFT.
  - SHIFT:
    - in_ready=0. in_valid is ignored, and no input is buffered.
    - Each edge:
      - every BCD digit >=5 has 3 added (4-bit result, no carry between digits);
      - then {bcd,bin} is shifted left by 1;
      - the counter decrements.
    - On the edge where the counter==1 (the WIDTH-th shift):
      - bcd_out <= sat ? all digits 9 : final accumulator;
      - ovf <= sat;
      - out_valid <= 1;
      - state <= IDLE.
- Latency:
  - Accept at edge N. bcd_out/out_valid update at edge N+WIDTH, which is 27 cycles at default.
  - Latency is fixed and does not depend on data or saturation.
- out_valid:
  - High for exactly one cycle, then cleared.
  - There is no backpressure; the downstream must sample during the pulse or use the held bcd_out.
- Throughput:
  - in_ready is high again in the same cycle as out_valid.
  - A new input may be accepted on the edge ending that cycle. Maximum throughput is therefore one conversion per WIDTH+1 cycles.
- bcd_out and ovf hold their values until the next completion or reset.
- Arithmetic:
  - Accumulator width is 4*DIGITS.
  - The saturation comparison is done against a WIDTH-bit constant MAX_VAL.
  - If WIDTH cannot represent MAX_VAL, the comparison is constant 0.

Optional Feature:
- Macro BIN2BCD_BLANK_EN.
- When defined:
  - adds output port blank_mask, direction out, width DIGITS;
  - bit i=1 when digit i and all more-significant digits are 0;
  - digit 0 is never blanked;
  - the mask is registered together with bcd_out, with reset value 0;
  - the scanner uses it to turn segments off.
- When undefined:
  - the port and its logic are absent;
  - all other behaviour is identical.

Decomposition:
- Package seg_pkg:
  - DIGITS_DEF=8, BCD_W=4, MAX_VAL=99_999_999;
  - state enum {IDLE, SHIFT};
  - SAT_PATTERN (all nines).
- One sub-module, bcd_digit_adj: combinational 4-bit "if >=5 add 3". It is instantiated DIGITS times via generate.

Test Plan:
- Reset, then in_bin=0 with a handshake → out_valid exactly 27 cycles after accept; bcd_out=32'h0000_0000, ovf=0, blank_mask=8'hFE.
- in_bin=12_345_678 → bcd_out=32'h1234_5678, ovf=0, blank_mask=8'h00. Then in_bin=1234 → 32'h0000_1234, blank_mask=8'hF0.
- in_bin=99_999_999 → 32'h9999_9999, ovf=0. in_bin=100_000_000 → 32'h9999_9999, ovf=1, same latency.
- in_valid held high with alternating values → in_ready low during SHIFT, inputs ignored. The next accept is on the edge ending the out_valid cycle, so back-to-back results are 28 cycles apart.
- rst=0 for one cycle at cycle 10 of a conversion → next cycle in_ready=1, out_valid=0, bcd_out=0, ovf=0; no pulse at cycle 27. A fresh in_bin=42 → 32'h0000_0042.
- Results hold: after one conversion with in_valid=0 for 100 cycles → bcd_out stable, out_valid low throughout.
